// File: rtl/shift_fifo_pkg.sv
// Shared sizing constants for the shift-register byte collector and its FIFO.
// No logic; constants only.
// No flow control here; consumers pick these up as parameter defaults.
package shift_fifo_pkg;

   localparam int DEF_WIDTH     = 8;                   // bits per assembled word
   localparam int DEF_DEPTH     = 4;                   // FIFO entries, power of two
   localparam int DEF_AW        = $clog2(DEF_DEPTH);   // FIFO pointer width
   localparam int DEF_BIT_CNT_W = $clog2(DEF_WIDTH);   // shift strobe counter width

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with sticky overflow/underflow flags.
// Latency: a write is visible on dout/valid one edge after it is accepted.
// Backpressure: none upstream; a write while full (and not popping) is dropped and flagged.
module sync_fifo_fwft
   import shift_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   logic          overflow_q,  overflow_d;
   logic          underflow_q, underflow_d;

   logic wr_done;
   logic rd_done;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));

   // A pop is only honoured when there is data; a push when there is room,
   // or when a simultaneous pop frees the head slot.
   assign rd_done = rd_en && !empty;
   assign wr_done = wr_en && (!full || rd_en);

   // Next-state for pointers, occupancy and sticky error flags.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_done) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_done) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (wr_done && !rd_done) begin
         count_d = count_q + (AW+1)'(1);
      end else if (!wr_done && rd_done) begin
         count_d = count_q - (AW+1)'(1);
      end

      if (wr_en && full && !rd_en) begin
         overflow_d = 1'b1;
      end
      if (rd_en && empty) begin
         underflow_d = 1'b1;
      end
   end

   // Control state register; reset wins over any concurrent push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array; contents are left as-is by reset, writes are blocked during it.
   always_ff @(posedge clk) begin
      if (!rst && wr_done) begin
         mem_q[wr_ptr_q] <= wr_dat;
      end
   end

   assign dout      = empty ? '0 : mem_q[rd_ptr_q];
   assign valid     = !empty;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: rtl/shift_byte_fifo.sv
// Counts upstream shift strobes and queues each completed parallel word into a FWFT FIFO.
// Latency: 2 edges from the final shift edge of a word to valid=1.
// Backpressure: none to the shifter; words arriving while the FIFO is full are dropped (overflow).
module shift_byte_fifo
   import shift_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic          word_rdy_q, word_rdy_d;

   // Advance the bit counter per strobe; flag the cycle after the last bit lands.
   // The upstream register updates on that same edge, so q_in is the full word
   // while word_rdy_q is high.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      word_rdy_d = 1'b0;
      if (shift_in) begin
         if (bit_cnt_q == CW'(WIDTH-1)) begin
            bit_cnt_d  = '0;
            word_rdy_d = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
         end
      end
   end

   // Counter and word-ready registers; reset drops any partially shifted word.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q  <= '0;
         word_rdy_q <= 1'b0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         word_rdy_q <= word_rdy_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (word_rdy_q),
      .wr_dat    (q_in),
      .rd_en     (rd_en),
      .dout      (dout),
      .valid     (valid),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

endmodule

// File: tb/tb_shift_byte_fifo.sv
module tb_shift_byte_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       shift_in;
   logic [7:0] q_in;
   logic       rd_en;
   logic [7:0] dout;
   logic       valid;
   logic       empty;
   logic       full;
   logic [2:0] count;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [7:0] sb[$];        // expected FIFO contents, head first
   logic [7:0] words_q[$];   // words to present on q_in at each word-ready cycle
   int         m_bit;
   logic       m_wr;
   int         m_cnt;
   logic       m_ovf;
   logic       m_unf;

   shift_byte_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .shift_in  (shift_in),
      .q_in      (q_in),
      .rd_en     (rd_en),
      .dout      (dout),
      .valid     (valid),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1; shift_in = 1'b0; rd_en = 1'b0; q_in = 8'h00;
      @(posedge clk); #1;
      rst = 1'b0;
      m_bit = 0; m_wr = 1'b0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
      sb.delete(); words_q.delete();
   endtask

   // One clock cycle of stimulus; pops are scored against the queue.
   task automatic cyc(input logic sh, input logic rd);
      logic       rdd, wrd;
      logic [7:0] w, exp;
      w = 8'($urandom);
      if (m_wr) w = (words_q.size() > 0) ? words_q.pop_front() : 8'h00;
      shift_in = sh; rd_en = rd; q_in = w;
      rdd = rd && (m_cnt != 0);
      wrd = m_wr && ((m_cnt < 4) || rd);
      if (rdd) begin
         exp = sb.pop_front();
         checks++;
         if (dout !== exp) begin
            errors++;
            $display("FAIL pop_data: dout=%h expected=%h", dout, exp);
         end
      end
      if (m_wr && m_cnt == 4 && !rd) m_ovf = 1'b1;
      if (rd && m_cnt == 0) m_unf = 1'b1;
      if (wrd) sb.push_back(w);
      m_cnt = m_cnt + int'(wrd) - int'(rdd);
      m_wr  = sh && (m_bit == 7);
      if (sh) m_bit = (m_bit + 1) % 8;
      @(posedge clk); #1;
      shift_in = 1'b0; rd_en = 1'b0;
      checks++;
      if (count !== 3'(m_cnt) || overflow !== m_ovf || underflow !== m_unf) begin
         errors++;
         $display("FAIL cycle_state: count=%0d ovf=%b unf=%b expected count=%0d ovf=%b unf=%b",
                  count, overflow, underflow, m_cnt, m_ovf, m_unf);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || valid !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL reset_flags: empty=%b full=%b valid=%b count=%0d expected 1 0 0 0",
                  empty, full, valid, count);
      end
      checks++;
      if (dout !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: dout=%h ovf=%b unf=%b expected 00 0 0", dout, overflow, underflow);
      end
   endtask

   task automatic test_single();
      words_q.push_back(8'hA5);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0);
         if (i < 7) cyc(1'b0, 1'b0);
      end
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early: valid=%b expected 0", valid);
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (valid !== 1'b1 || dout !== 8'hA5 || count !== 3'd1) begin
         errors++;
         $display("FAIL single_word: valid=%b dout=%h count=%0d expected 1 a5 1", valid, dout, count);
      end
      cyc(1'b0, 1'b1);
      checks++;
      if (empty !== 1'b1 || dout !== 8'h00) begin
         errors++;
         $display("FAIL single_pop: empty=%b dout=%h expected 1 00", empty, dout);
      end
   endtask

   task automatic test_overflow();
      words_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      checks++;
      if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b1 || dout !== 8'h11) begin
         errors++;
         $display("FAIL overflow_fill: count=%0d full=%b ovf=%b dout=%h expected 4 1 1 11",
                  count, full, overflow, dout);
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL overflow_drain: empty=%b expected 1", empty);
      end
   endtask

   task automatic test_full_rw();
      do_reset();
      words_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
      for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      checks++;
      if (count !== 3'd4 || overflow !== 1'b0 || dout !== 8'h22) begin
         errors++;
         $display("FAIL full_rw: count=%0d ovf=%b dout=%h expected 4 0 22", count, overflow, dout);
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
   endtask

   task automatic test_underflow();
      cyc(1'b0, 1'b1);
      checks++;
      if (underflow !== 1'b1 || count !== 3'd0) begin
         errors++;
         $display("FAIL underflow_set: unf=%b count=%0d expected 1 0", underflow, count);
      end
      words_q.push_back(8'h77);
      for (int i = 0; i < 9; i++) cyc(i < 8, 1'b0);
      checks++;
      if (dout !== 8'h77 || underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow_sticky: dout=%h unf=%b expected 77 1", dout, underflow);
      end
      cyc(1'b0, 1'b1);
      do_reset();
      checks++;
      if (underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_clear: unf=%b expected 0", underflow);
      end
   endtask

   task automatic test_reset_midword();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
      do_reset();
      words_q.push_back(8'h3C);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      checks++;
      if (count !== 3'd1 || dout !== 8'h3C) begin
         errors++;
         $display("FAIL reset_midword: count=%0d dout=%h expected 1 3c", count, dout);
      end
   endtask

   task automatic test_back_to_back_wrap();
      do_reset();
      words_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hDE, 8'hAD};
      for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      checks++;
      if (count !== 3'd2 || dout !== 8'hDE) begin
         errors++;
         $display("FAIL wrap_head: count=%0d dout=%h expected 2 de", count, dout);
      end
      cyc(1'b0, 1'b1);
      checks++;
      if (dout !== 8'hAD) begin
         errors++;
         $display("FAIL wrap_second: dout=%h expected ad", dout);
      end
      cyc(1'b0, 1'b1);
      checks++;
      if (count !== 3'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL wrap_empty: count=%0d empty=%b expected 0 1", count, empty);
      end
   endtask

   initial begin
      rst = 1'b1; shift_in = 1'b0; rd_en = 1'b0; q_in = 8'h00;
      test_reset();
      test_single();
      test_overflow();
      test_full_rw();
      test_underflow();
      test_reset_midword();
      test_back_to_back_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_byte_fifo.md
Name: shift_byte_fifo

Overview:
Downstream stage of the 8-bit serial-in/parallel-out shift register. Counts the upstream shift strobes, and once a full word has been shifted in it captures the parallel output into a small synchronous FIFO. The FIFO is first-word-fall-through, so the consumer drains assembled bytes with a valid/read handshake. One clock domain.

Parameters:
WIDTH, 8, bits per word; equals the upstream shift register width.
DEPTH, 4, FIFO entries; power of two, at least 2.
AW, 2, pointer width; equals log2(DEPTH).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
shift_in  input  1  the same shift strobe that drives the upstream shift register; one bit is shifted per cycle in which it is high.
q_in  input  WIDTH  parallel output of the upstream shift register.
rd_en  input  1  pop request from the consumer.
dout  output  WIDTH  head-of-FIFO word (FWFT); 0 when empty.
valid  output  1  high when the FIFO is not empty (equals !empty).
empty  output  1  FIFO holds no words.
full  output  1  FIFO holds DEPTH words.
count  output  AW+1  number of words stored, 0..DEPTH.
overflow  output  1  sticky; a completed word was dropped because the FIFO was full.
underflow  output  1  sticky; rd_en was asserted while the FIFO was empty.

Behaviour:
- Reset (rst=1 at an edge): bit_cnt=0, word_rdy=0, wr_ptr=rd_ptr=0, count=0, overflow=0, underflow=0. This gives empty=1, full=0, valid=0, dout=0. Memory contents are not reset. Reset has priority over every other input.
- Bit counter: bit_cnt (log2(WIDTH) bits) increments on each edge with shift_in=1. On shift_in=1 with bit_cnt==WIDTH-1 it wraps to 0 and word_rdy is set for exactly one cycle; otherwise word_rdy is 0.
- Capture timing: the upstream register updates q_in on the same edge that sets word_rdy. During the word_rdy=1 cycle, q_in therefore holds the completed word. The write to mem[wr_ptr] happens at the edge that ends that cycle. Latency is 2 edges from the 8th shift edge to valid=1.
- A shift_in pulse during the word_rdy cycle counts as bit 0 of the next word. Back-to-back words with continuous shift_in are supported.
- Write: if word_rdy and not full, mem[wr_ptr]<=q_in and wr_ptr increments, wrapping modulo DEPTH.
- Write while full: if word_rdy and full and rd_en, the read and the write both occur and count stays DEPTH. If word_rdy and full and no rd_en, the word is dropped, overflow<=1, and pointers are unchanged.
- Read: if rd_en and not empty, rd_ptr increments, wrapping modulo DEPTH. dout is combinational from mem[rd_ptr], gated to 0 when empty.
- Read while empty: rd_en with empty is ignored and sets underflow<=1. This applies even when a write occurs in the same cycle; the written word appears as valid next cycle.
- Count: count <= count + write_done - read_done. full = (count==DEPTH); empty = (count==0).
- Sticky flags are cleared only by rst.
- Reset mid-word discards the partial bit_cnt. The next word requires WIDTH fresh shift pulses.

Decomposition:
- Package shift_fifo_pkg holds the WIDTH/DEPTH defaults, AW, and the bit-counter width constant.
- One sub-module, sync_fifo_fwft, contains the memory, pointers, count, full/empty, and the overflow/underflow logic.
- shift_byte_fifo contains the bit counter, word_rdy, and the sync_fifo_fwft instance.

Test Plan:
- After rst, 8 single-cycle shift_in pulses; q_in=8'hA5 in the word_rdy cycle → 2 edges after the 8th pulse: valid=1, dout=8'hA5, count=1. Pulse rd_en once → empty=1, dout=0.
- Continuous shift_in for 40 cycles with q_in=8'h11,22,33,44,55 at each word_rdy, no reads → count=4, full=1, overflow=1, dout=8'h11. Pop 4 → dout sequence 11,22,33,44, then empty.
- At full, word_rdy coincides with rd_en (q_in=8'h66) → count stays 4, overflow stays 0, next dout=8'h22.
- rd_en while empty → underflow=1, count=0, pointers unchanged. underflow stays 1 until rst.
- 5 shift pulses, then rst, then 8 pulses with q_in=8'h3C → exactly one word 8'h3C is written, none after the 3rd post-reset pulse.
- Pointer wrap: write 4 words, read 4, write 8'hDE, 8'hAD → read order DE, AD; count returns to 0.
